// File: rtl/tdc_ctrl_pkg.sv
// Shared types and constants for the TDC measurement controller.
// Used by tdc_ctrl and tdc_therm_decode.
package tdc_ctrl_pkg;

  localparam int DATA_WIDTH_DEF = 252;
  localparam int CNT_WIDTH      = 8;
  localparam int CLEAR_CYCLES   = 2;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ARM,
    LAUNCH,
    STOP,
    SETTLE,
    ACCUM,
    REPORT
  } state_t;

endpackage

// File: rtl/tdc_therm_decode.sv
// Thermometer-code decoder: run length of ones from bit 0.
// Bubble flag port exists only with TDC_CTRL_BUBBLE_CHECK_EN.
module tdc_therm_decode
  import tdc_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic [DATA_WIDTH-1:0] dout_i,
`ifdef TDC_CTRL_BUBBLE_CHECK_EN
  output logic                  bubble_o,
`endif
  output logic [CNT_WIDTH-1:0]  count_o
);

  logic run;

  // Count ones until the first zero
  always_comb begin
    count_o = '0;
    run     = 1'b1;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (run && dout_i[i]) count_o = count_o + 1'b1;
      else                  run     = 1'b0;
    end
  end

`ifdef TDC_CTRL_BUBBLE_CHECK_EN
  // Any one above the first zero breaks the thermometer
  always_comb begin
    bubble_o = |(dout_i >> count_o);
  end
`endif

endmodule

// File: rtl/tdc_ctrl.sv
// TDC batch controller: clear/arm/launch/stop/settle/accumulate.
// Optional bubble detection with TDC_CTRL_BUBBLE_CHECK_EN.
module tdc_ctrl
  import tdc_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ACC_WIDTH  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            num_samples,
  input  logic [3:0]            settle_cycles,
  output logic                  busy,
  output logic                  tdc_a,
  output logic                  tdc_b,
  output logic                  tdc_reset_b,
  input  logic [DATA_WIDTH-1:0] tdc_dout,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [ACC_WIDTH-1:0]  res_sum,
  output logic [7:0]            res_min,
  output logic [7:0]            res_max,
  output logic                  res_err
);

  state_t               state_q, state_d;
  logic [1:0]           clr_q, clr_d;
  logic [3:0]           settle_q, settle_d;
  logic [3:0]           scnt_q, scnt_d;
  logic [7:0]           rem_q, rem_d;
  logic [ACC_WIDTH-1:0] sum_q, sum_d;
  logic [7:0]           min_q, min_d;
  logic [7:0]           max_q, max_d;
  logic                 a_d, b_d, rb_d, valid_d, busy_d;
  logic [CNT_WIDTH-1:0] count;

`ifdef TDC_CTRL_BUBBLE_CHECK_EN
  logic bubble;
  logic err_q, err_d;

  tdc_therm_decode #(.DATA_WIDTH(DATA_WIDTH)) u_dec (
    .dout_i   (tdc_dout),
    .bubble_o (bubble),
    .count_o  (count)
  );

  // Sticky bubble flag, cleared when a batch is accepted
  always_comb begin
    err_d = err_q;
    if (state_q == IDLE && start) err_d = 1'b0;
    else if (state_q == ACCUM)    err_d = err_q | bubble;
  end

  // Bubble flag register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign res_err = err_q;
`else
  tdc_therm_decode #(.DATA_WIDTH(DATA_WIDTH)) u_dec (
    .dout_i  (tdc_dout),
    .count_o (count)
  );

  assign res_err = 1'b0;
`endif

  // Next-state and datapath updates
  always_comb begin
    state_d  = state_q;
    clr_d    = clr_q;
    settle_d = settle_q;
    scnt_d   = scnt_q;
    rem_d    = rem_q;
    sum_d    = sum_q;
    min_d    = min_q;
    max_d    = max_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = CLEAR;
          clr_d    = '0;
          settle_d = settle_cycles;
          rem_d    = (num_samples == 8'd0) ? 8'd1 : num_samples;
          sum_d    = '0;
          min_d    = 8'hFF;
          max_d    = '0;
        end
      end
      CLEAR: begin
        if (clr_q == 2'(CLEAR_CYCLES - 1)) state_d = ARM;
        else                               clr_d   = clr_q + 2'd1;
      end
      ARM:    state_d = LAUNCH;
      LAUNCH: state_d = STOP;
      STOP: begin
        scnt_d  = settle_q;
        state_d = (settle_q == 4'd0) ? ACCUM : SETTLE;
      end
      SETTLE: begin
        if (scnt_q <= 4'd1) state_d = ACCUM;
        else                scnt_d  = scnt_q - 4'd1;
      end
      ACCUM: begin
        sum_d = sum_q + ACC_WIDTH'(count);
        if (count < min_q) min_d = count;
        if (count > max_q) max_d = count;
        rem_d = rem_q - 8'd1;
        if (rem_q > 8'd1) begin
          state_d = CLEAR;
          clr_d   = '0;
        end else begin
          state_d = REPORT;
        end
      end
      REPORT: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output levels decoded from the upcoming state
  always_comb begin
    a_d     = state_d inside {LAUNCH, STOP, SETTLE, ACCUM};
    b_d     = state_d inside {STOP, SETTLE, ACCUM};
    rb_d    = state_d inside {ARM, LAUNCH, STOP, SETTLE, ACCUM};
    valid_d = (state_d == REPORT);
    busy_d  = (state_d != IDLE);
  end

  // State, datapath and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      clr_q       <= '0;
      settle_q    <= '0;
      scnt_q      <= '0;
      rem_q       <= '0;
      sum_q       <= '0;
      min_q       <= '0;
      max_q       <= '0;
      tdc_a       <= 1'b0;
      tdc_b       <= 1'b0;
      tdc_reset_b <= 1'b0;
      res_valid   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_q       <= clr_d;
      settle_q    <= settle_d;
      scnt_q      <= scnt_d;
      rem_q       <= rem_d;
      sum_q       <= sum_d;
      min_q       <= min_d;
      max_q       <= max_d;
      tdc_a       <= a_d;
      tdc_b       <= b_d;
      tdc_reset_b <= rb_d;
      res_valid   <= valid_d;
      busy        <= busy_d;
    end
  end

  assign res_sum = sum_q;
  assign res_min = min_q;
  assign res_max = max_q;

endmodule

// File: tb/tb_tdc_ctrl.sv
// Self-checking bench for tdc_ctrl with a batch-level reference model.
// Bubble expectations follow TDC_CTRL_BUBBLE_CHECK_EN.
module tb_tdc_ctrl;

  localparam int W  = 252;
  localparam int AW = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [7:0]    num_samples = '0;
  logic [3:0]    settle_cycles = '0;
  logic [W-1:0]  tdc_dout = '0;
  logic          res_ready = 1'b0;
  logic          busy, tdc_a, tdc_b, tdc_reset_b;
  logic          res_valid, res_err;
  logic [AW-1:0] res_sum;
  logic [7:0]    res_min, res_max;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  tdc_ctrl #(.DATA_WIDTH(W), .ACC_WIDTH(AW)) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .num_samples   (num_samples),
    .settle_cycles (settle_cycles),
    .busy          (busy),
    .tdc_a         (tdc_a),
    .tdc_b         (tdc_b),
    .tdc_reset_b   (tdc_reset_b),
    .tdc_dout      (tdc_dout),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_sum       (res_sum),
    .res_min       (res_min),
    .res_max       (res_max),
    .res_err       (res_err)
  );

  function automatic logic [W-1:0] therm(input int n);
    logic [W-1:0] v = '0;
    for (int i = 0; i < n; i++) v[i] = 1'b1;
    return v;
  endfunction

  function automatic int ref_count(input logic [W-1:0] d);
    int c = 0;
    while (c < W && d[c]) c++;
    return c;
  endfunction

  function automatic bit ref_bubble(input logic [W-1:0] d);
    int hi = -1;
    for (int i = 0; i < W; i++) if (d[i]) hi = i;
    return hi >= ref_count(d);
  endfunction

  task automatic run_batch(input string name, input int num,
                           input int settle, input logic [W-1:0] douts[$],
                           input int hold, input bit noise);
    int eff, L, sum, mn, mx, bad_idx;
    bit err;
    logic [2:0] wave[$];
    logic [2:0] obs;
    eff = (num == 0) ? 1 : num;
    L = 6 + settle;
    sum = 0; mn = 255; mx = 0; err = 1'b0;
    for (int s = 0; s < eff; s++) begin
      int c = ref_count(douts[s]);
      sum += c;
      if (c < mn) mn = c;
      if (c > mx) mx = c;
      err |= ref_bubble(douts[s]);
      wave.push_back(3'b000);
      wave.push_back(3'b000);
      wave.push_back(3'b001);
      wave.push_back(3'b101);
      wave.push_back(3'b111);
      for (int k = 0; k < settle; k++) wave.push_back(3'b111);
      wave.push_back(3'b111);
    end
`ifndef TDC_CTRL_BUBBLE_CHECK_EN
    err = 1'b0;
`endif
    @(negedge clock);
    start = 1'b1;
    num_samples = 8'(num);
    settle_cycles = 4'(settle);
    tdc_dout = douts[0];
    @(negedge clock);
    start = 1'b0;
    bad_idx = -1;
    for (int i = 0; i < wave.size(); i++) begin
      if (i % L == 0) tdc_dout = douts[i / L];
      obs = {tdc_a, tdc_b, tdc_reset_b};
      if (bad_idx < 0 && (obs !== wave[i] || busy !== 1'b1 ||
                          res_valid !== 1'b0))
        bad_idx = i;
      if (noise) start = 1'($urandom % 2);
      @(negedge clock);
    end
    start = 1'b0;
    n_tests++;
    if (bad_idx >= 0) begin
      n_fail++;
      $display("FAIL %s wave: first bad cycle %0d of %0d (a/b/rb/busy/valid wrong)",
               name, bad_idx, wave.size());
    end
    n_tests++;
    if (res_valid !== 1'b1 || busy !== 1'b1 ||
        {tdc_a, tdc_b, tdc_reset_b} !== 3'b000) begin
      n_fail++;
      $display("FAIL %s report: valid=%b busy=%b abr=%b, want 1 1 000",
               name, res_valid, busy, {tdc_a, tdc_b, tdc_reset_b});
    end
    n_tests++;
    if (res_sum !== 16'(sum) || res_min !== 8'(mn) ||
        res_max !== 8'(mx) || res_err !== err) begin
      n_fail++;
      $display("FAIL %s result: sum=%0d min=%0d max=%0d err=%b, want %0d %0d %0d %b",
               name, res_sum, res_min, res_max, res_err, sum, mn, mx, err);
    end
    if (hold > 0) begin
      bad_idx = -1;
      for (int h = 0; h < hold; h++) begin
        res_ready = 1'b0;
        start = noise ? 1'(h % 2) : 1'b0;
        @(negedge clock);
        if (bad_idx < 0 && (res_valid !== 1'b1 || res_sum !== 16'(sum) ||
                            res_min !== 8'(mn) || res_max !== 8'(mx)))
          bad_idx = h;
      end
      start = 1'b0;
      n_tests++;
      if (bad_idx >= 0) begin
        n_fail++;
        $display("FAIL %s hold: result changed at cycle %0d, valid=%b sum=%0d want 1 %0d",
                 name, bad_idx, res_valid, res_sum, sum);
      end
    end
    res_ready = 1'b1;
    @(negedge clock);
    res_ready = 1'b0;
    n_tests++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s idle: valid=%b busy=%b, want 0 0",
               name, res_valid, busy);
    end
    @(negedge clock);
    n_tests++;
    if (busy !== 1'b0 || tdc_reset_b !== 1'b0) begin
      n_fail++;
      $display("FAIL %s stay_idle: busy=%b rb=%b, want 0 0",
               name, busy, tdc_reset_b);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    n_tests++;
    if ({busy, tdc_a, tdc_b, tdc_reset_b, res_valid, res_err,
         res_sum, res_min, res_max} !== '0) begin
      n_fail++;
      $display("FAIL reset: busy=%b a=%b b=%b rb=%b v=%b e=%b sum=%0d min=%0d max=%0d, want all 0",
               busy, tdc_a, tdc_b, tdc_reset_b, res_valid, res_err,
               res_sum, res_min, res_max);
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_single();
    logic [W-1:0] q[$];
    q = {therm(8)};
    run_batch("single", 1, 0, q, 0, 1'b0);
  endtask

  task automatic test_three();
    logic [W-1:0] q[$];
    q = {therm(10), therm(20), therm(15)};
    run_batch("three", 3, 0, q, 0, 1'b0);
  endtask

  task automatic test_settle();
    logic [W-1:0] q[$];
    q = {~W'(0), ~W'(0)};
    run_batch("zero_num", 0, 5, q, 0, 1'b0);
    run_batch("settle5", 2, 5, q, 0, 1'b0);
    q = {'0, ~W'(0)};
    run_batch("min_max_edge", 2, 1, q, 0, 1'b0);
  endtask

  task automatic test_hold();
    logic [W-1:0] q[$];
    q = {therm(33), therm(7)};
    run_batch("hold", 2, 3, q, 10, 1'b1);
  endtask

  task automatic test_bubble();
    logic [W-1:0] q[$];
    logic [W-1:0] v;
    v = W'(4'b1011);
    q = {therm(5), v};
    run_batch("bubble", 2, 0, q, 0, 1'b0);
    q = {therm(9)};
    run_batch("err_clear", 1, 0, q, 0, 1'b0);
  endtask

  task automatic test_random();
    logic [W-1:0] q[$];
    logic [W-1:0] v;
    int num, settle;
    for (int b = 0; b < 10; b++) begin
      q.delete();
      num = int'($urandom_range(0, 6));
      settle = int'($urandom_range(0, 15));
      for (int s = 0; s < ((num == 0) ? 1 : num); s++) begin
        v = therm(int'($urandom_range(0, W)));
        if ($urandom % 4 == 0) v[$urandom_range(0, W - 1)] = ~v[0];
        q.push_back(v);
      end
      run_batch($sformatf("rand%0d", b), num, settle, q,
                int'($urandom_range(0, 3)), 1'b1);
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] q[$];
    @(negedge clock);
    start = 1'b1;
    num_samples = 8'd4;
    settle_cycles = 4'd5;
    tdc_dout = ~W'(0);
    @(posedge clock);
    #1 start = 1'b0;
    repeat (17) @(posedge clock);
    #2;
    n_tests++;
    if ({tdc_a, tdc_b, tdc_reset_b, busy} !== 4'b1111) begin
      n_fail++;
      $display("FAIL mid_settle: abr_busy=%b, want 1111",
               {tdc_a, tdc_b, tdc_reset_b, busy});
    end
    reset = 1'b1;
    #1;
    n_tests++;
    if ({busy, tdc_a, tdc_b, tdc_reset_b, res_valid, res_err,
         res_sum, res_min, res_max} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: busy=%b a=%b b=%b rb=%b v=%b sum=%0d min=%0d max=%0d, want all 0",
               busy, tdc_a, tdc_b, tdc_reset_b, res_valid,
               res_sum, res_min, res_max);
    end
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    n_tests++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset: valid=%b busy=%b, want 0 0", res_valid, busy);
    end
    q = {therm(3), therm(100)};
    run_batch("after_reset", 2, 2, q, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_three();
    test_settle();
    test_hold();
    test_bubble();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tdc_ctrl.md
TDC_CTRL -- requirements
Module: tdc_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 252, TDC thermometer width.
REQ-002 Parameter ACC_WIDTH, default 16, accumulator width.
REQ-003 clock  in  1  sole clock, rising edge.
REQ-004 reset  in  1  asynchronous, active-high.
REQ-005 start  in  1  single-cycle request to begin a measurement batch.
REQ-006 num_samples  in  8  samples per batch; sampled at start; 0 treated as 1.
REQ-007 settle_cycles  in  4  wait cycles after stop edge before sampling dout; sampled at start.
REQ-008 busy  out  1  high from the cycle after accepted start until return to IDLE.
REQ-009 tdc_a  out  1  TDC start edge, registered.
REQ-010 tdc_b  out  1  TDC stop edge, registered.
REQ-011 tdc_reset_b  out  1  TDC active-low reset, registered.
REQ-012 tdc_dout  in  DATA_WIDTH  TDC captured thermometer code.
REQ-013 res_valid  out  1  batch result valid.
REQ-014 res_ready  in  1  result consumer ready.
REQ-015 res_sum  out  ACC_WIDTH  sum of per-sample counts.
REQ-016 res_min / res_max  out  8 each  minimum / maximum per-sample count.
REQ-017 res_err  out  1  bubble detected in any sample of batch.

Function
REQ-018 FSM states SHALL be IDLE, CLEAR, ARM, LAUNCH, STOP, SETTLE, ACCUM, REPORT.
REQ-019 IDLE: start=1 -> CLEAR; latch num_samples, settle_cycles; clear sum=0, min=255, max=0, err=0.
REQ-020 CLEAR: 2 cycles, tdc_reset_b=0, tdc_a=0, tdc_b=0; then ARM.
REQ-021 ARM: 1 cycle, tdc_reset_b=1, tdc_a=0, tdc_b=0; then LAUNCH.
REQ-022 LAUNCH: 1 cycle, tdc_a=1; then STOP.
REQ-023 STOP: 1 cycle, tdc_a=1, tdc_b=1; then SETTLE (or ACCUM if settle_cycles=0).
REQ-024 SETTLE: hold tdc_a=tdc_b=1 for settle_cycles cycles; then ACCUM.
REQ-025 ACCUM: 1 cycle; count = number of consecutive ones in tdc_dout from bit 0 (0..DATA_WIDTH, 8 bits); sum+=count, min/max updated; remaining decremented; remaining>0 -> CLEAR, else REPORT.
REQ-026 Per-sample latency SHALL be exactly 6+settle_cycles cycles.
REQ-027 REPORT: res_valid=1, result registers stable; transfer on res_valid&res_ready -> IDLE next cycle, res_valid=0.
REQ-028 start while busy or in REPORT SHALL be ignored.
REQ-029 sum SHALL not overflow: 256*252 < 2^16; no saturation logic.
REQ-030 All-ones dout -> count=DATA_WIDTH; dout bit0=0 -> count=0.
REQ-031 In IDLE/REPORT outputs tdc_a=0, tdc_b=0, tdc_reset_b=0.

Reset
REQ-032 reset SHALL asynchronously force IDLE, busy=0, tdc_a=0, tdc_b=0, tdc_reset_b=0, res_valid=0, res_sum=0, res_min=0, res_max=0, res_err=0.
REQ-033 reset mid-batch SHALL discard partial results; no res_valid until a new batch completes.

Configuration
REQ-034 Macro TDC_CTRL_BUBBLE_CHECK_EN defined: any 0 bit below a 1 bit in tdc_dout (non-thermometer) sets err, sticky for the batch, shown on res_err.
REQ-035 Macro undefined: no bubble logic; res_err tied 0.

Structure
REQ-036 Package tdc_ctrl_pkg SHALL hold the state enum, DATA_WIDTH default, CNT_WIDTH=8, CLEAR_CYCLES=2.
REQ-037 Sub-module tdc_therm_decode SHALL be combinational: dout -> count, bubble flag (flag only under macro).

Verification
REQ-038 num_samples=1, settle=0, dout=0x..0FF (8 ones) -> res_valid at cycle 7 after start; sum=8, min=8, max=8, err=0.
REQ-039 num_samples=3, dout per sample 10, 20, 15 ones -> sum=45, min=10, max=20; tdc_a/tdc_b/tdc_reset_b waveform per REQ-020..024 each sample.
REQ-040 settle=5, all-ones dout -> sample every 11 cycles; count=252; num_samples=0 yields exactly one sample.
REQ-041 res_ready held low 10 cycles in REPORT -> res_valid and results held; start pulses ignored; IDLE one cycle after ready.
REQ-042 reset asserted during SETTLE of sample 2 of 4 -> all outputs reset values immediately; new start gives clean batch.
REQ-043 With TDC_CTRL_BUBBLE_CHECK_EN, dout=0b1011 in one sample -> count=2, res_err=1; without macro res_err=0.
